// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA window timing generator.
package vga_timing_pkg;

  // Phase of one raster axis
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FP     = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BP     = 2'd3
  } axis_state_e;

  // Per-pixel control bits carried down the alignment pipeline
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic inwin;
    logic fs;
  } pix_ctrl_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Full length of an axis (active + porches + sync)
  function automatic int total_len(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FP/SYNC/BP phase machine.
// The counter and the phase machine both advance only when step is high.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = 1'b0,
  localparam int  TOTAL  = total_len(ACTIVE, FP, SYNC, BP),
  localparam int  W      = $clog2(TOTAL)
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_len_check
    $error("vga_axis_counter: every phase needs a length of at least 1");
  end

  axis_state_e  state_r, state_n;
  logic [W-1:0] count_r, count_n;
  logic [W-1:0] seg_r, seg_n;
  logic [W-1:0] seg_last_s;

  // Terminal per-phase count for the current phase
  always_comb begin
    seg_last_s = W'(ACTIVE - 1);
    case (state_r)
      ST_ACTIVE: seg_last_s = W'(ACTIVE - 1);
      ST_FP:     seg_last_s = W'(FP - 1);
      ST_SYNC:   seg_last_s = W'(SYNC - 1);
      ST_BP:     seg_last_s = W'(BP - 1);
      default:   seg_last_s = W'(ACTIVE - 1);
    endcase
  end

  // Next position, next phase and next in-phase count
  always_comb begin
    state_n = state_r;
    seg_n   = seg_r;
    count_n = count_r;
    if (step) begin
      count_n = (count_r == LAST) ? '0 : count_r + 1'b1;
      if (seg_r == seg_last_s) begin
        seg_n = '0;
        case (state_r)
          ST_ACTIVE: state_n = ST_FP;
          ST_FP:     state_n = ST_SYNC;
          ST_SYNC:   state_n = ST_BP;
          ST_BP:     state_n = ST_ACTIVE;
          default:   state_n = ST_ACTIVE;
        endcase
      end else begin
        seg_n = seg_r + 1'b1;
      end
    end else begin
      count_n = count_r;
    end
  end

  // Axis state registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_ACTIVE;
      seg_r   <= '0;
      count_r <= '0;
    end else begin
      state_r <= state_n;
      seg_r   <= seg_n;
      count_r <= count_n;
    end
  end

  assign count  = count_r;
  assign wrap   = step && (count_r == LAST);
  assign active = (state_r == ST_ACTIVE);
  assign sync   = (state_r == ST_SYNC) ? POL : ~POL;

endmodule

// File: rtl/vga_window_timing_gen.sv
// VGA raster timing generator with a windowed framebuffer fetch.
// Counters -> address stage -> (MEM_LATENCY) -> output stage; every pin lags
// the counters by MEM_LATENCY+2 clocks.
module vga_window_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   WIN_X       = 192,
  parameter int   WIN_Y       = 112,
  parameter int   WIN_W       = 256,
  parameter int   WIN_H       = 256,
  parameter int   ADDR_W      = 16,
  parameter int   COLOR_W     = 3,
  parameter int   MEM_LATENCY = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [COLOR_W-1:0] iBorderColor,
  input  logic [COLOR_W-1:0] iColor,
  output logic [ADDR_W-1:0]  oReadAddress,
  output logic               oRed,
  output logic               oGreen,
  output logic               oBlue,
  output logic               oHSync,
  output logic               oVSync,
  output logic               oDataEnable,
  output logic               oFrameStart
);

  localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int STAGES  = MEM_LATENCY + 1;

  localparam pix_ctrl_t CTRL_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL,
                                      de: 1'b0, inwin: 1'b0, fs: 1'b0};

  if (WIN_X + WIN_W > H_ACTIVE || WIN_Y + WIN_H > V_ACTIVE) begin : g_win_check
    $error("vga_window_timing_gen: window exceeds the active area");
  end
  if ((64'd1 << ADDR_W) < 64'(WIN_W * WIN_H)) begin : g_addr_check
    $error("vga_window_timing_gen: ADDR_W too narrow for the window");
  end
  if (MEM_LATENCY < 0 || MEM_LATENCY > 4) begin : g_lat_check
    $error("vga_window_timing_gen: MEM_LATENCY must be 0..4");
  end
  if (COLOR_W < 3) begin : g_color_check
    $error("vga_window_timing_gen: COLOR_W must provide R, G and B bits");
  end

  logic [HW-1:0] h_count_s;
  logic [VW-1:0] v_count_s;
  logic          h_wrap_s, v_wrap_s;
  logic          h_active_s, v_active_s;
  logic          h_sync_s, v_sync_s;
  logic          frame_pend_r;
  logic          inwin_s;
  pix_ctrl_t     ctrl_s;
  pix_ctrl_t     chain_s [STAGES+1];
  pix_ctrl_t     dly_s;
  logic [COLOR_W-1:0] color_s;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h_axis (
    .Clock(Clock), .Reset(Reset), .step(1'b1),
    .count(h_count_s), .wrap(h_wrap_s), .active(h_active_s), .sync(h_sync_s)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v_axis (
    .Clock(Clock), .Reset(Reset), .step(h_wrap_s),
    .count(v_count_s), .wrap(v_wrap_s), .active(v_active_s), .sync(v_sync_s)
  );

  // High while the counters sit on (0,0): set by reset and by the end-of-frame wrap
  always_ff @(posedge Clock) begin
    if (Reset) begin
      frame_pend_r <= 1'b1;
    end else begin
      frame_pend_r <= v_wrap_s;
    end
  end

  assign inwin_s = (int'(h_count_s) >= WIN_X) && (int'(h_count_s) < WIN_X + WIN_W) &&
                   (int'(v_count_s) >= WIN_Y) && (int'(v_count_s) < WIN_Y + WIN_H);

  assign ctrl_s = '{hsync: h_sync_s, vsync: v_sync_s, de: h_active_s && v_active_s,
                    inwin: inwin_s, fs: frame_pend_r};

  // Window-relative linear read address, zero outside the window
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oReadAddress <= '0;
    end else if (inwin_s) begin
      oReadAddress <= ADDR_W'((int'(v_count_s) - WIN_Y) * WIN_W + (int'(h_count_s) - WIN_X));
    end else begin
      oReadAddress <= '0;
    end
  end

  assign chain_s[0] = ctrl_s;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pix_ctrl_t q_r;
    // Delay the control bits so they meet the memory data at the output stage
    always_ff @(posedge Clock) begin
      if (Reset) begin
        q_r <= CTRL_IDLE;
      end else begin
        q_r <= chain_s[g];
      end
    end
    assign chain_s[g+1] = q_r;
  end

  assign dly_s = chain_s[STAGES];

  // Pixel colour: memory inside the window, border elsewhere in the active area, black in blanking
  always_comb begin
    color_s = '0;
    if (dly_s.de && dly_s.inwin) begin
      color_s = iColor;
    end else if (dly_s.de) begin
      color_s = iBorderColor;
    end else begin
      color_s = '0;
    end
  end

  // Registered pin stage
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oRed        <= 1'b0;
      oGreen      <= 1'b0;
      oBlue       <= 1'b0;
      oHSync      <= ~HS_POL;
      oVSync      <= ~VS_POL;
      oDataEnable <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      oRed        <= color_s[COLOR_W-1];
      oGreen      <= color_s[COLOR_W-2];
      oBlue       <= color_s[COLOR_W-3];
      oHSync      <= dly_s.hsync;
      oVSync      <= dly_s.vsync;
      oDataEnable <= dly_s.de;
      oFrameStart <= dly_s.fs;
    end
  end

endmodule

// File: tb/tb_vga_window_timing_gen.sv
// Randomized bench for vga_window_timing_gen: two scaled-down instances
// (active-low syncs / latency 1, and active-high syncs / latency 3 with a
// window at the origin) checked cycle by cycle against a raster model.
module tb_vga_window_timing_gen;

  typedef struct {
    int ha, hfp, hsy, hbp, va, vfp, vsy, vbp;
    int wx, wy, ww, wh, aw, ml, hpol, vpol;
  } cfg_t;

  typedef struct {
    bit hs_on, vs_on, de, inwin, fs;
    int addr;
  } pix_t;

  // Instance A parameters
  localparam int A_HA = 40, A_HFP = 4, A_HSY = 6, A_HBP = 5;
  localparam int A_VA = 30, A_VFP = 3, A_VSY = 2, A_VBP = 4;
  localparam int A_WX = 8, A_WY = 6, A_WW = 16, A_WH = 16, A_AW = 8, A_ML = 1;
  // Instance B parameters
  localparam int B_HA = 80, B_HFP = 4, B_HSY = 8, B_HBP = 8;
  localparam int B_VA = 40, B_VFP = 2, B_VSY = 3, B_VBP = 5;
  localparam int B_WX = 0, B_WY = 0, B_WW = 64, B_WH = 32, B_AW = 11, B_ML = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] border_a, border_b;
  logic [2:0] icol_a, icol_b;
  logic [A_AW-1:0] addr_a;
  logic [B_AW-1:0] addr_b;
  logic r_a, g_a, b_a, hs_a, vs_a, de_a, fs_a;
  logic r_b, g_b, b_b, hs_b, vs_b, de_b, fs_b;
  logic [31:0] seed;
  logic [2:0] ram_b_d [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_window_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HSY), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VSY), .V_BP(A_VBP),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .WIN_X(A_WX), .WIN_Y(A_WY), .WIN_W(A_WW), .WIN_H(A_WH),
    .ADDR_W(A_AW), .COLOR_W(3), .MEM_LATENCY(A_ML)
  ) dut_a (
    .Clock(clk), .Reset(rst), .iBorderColor(border_a), .iColor(icol_a),
    .oReadAddress(addr_a), .oRed(r_a), .oGreen(g_a), .oBlue(b_a),
    .oHSync(hs_a), .oVSync(vs_a), .oDataEnable(de_a), .oFrameStart(fs_a)
  );

  vga_window_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HSY), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VSY), .V_BP(B_VBP),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .WIN_X(B_WX), .WIN_Y(B_WY), .WIN_W(B_WW), .WIN_H(B_WH),
    .ADDR_W(B_AW), .COLOR_W(3), .MEM_LATENCY(B_ML)
  ) dut_b (
    .Clock(clk), .Reset(rst), .iBorderColor(border_b), .iColor(icol_b),
    .oReadAddress(addr_b), .oRed(r_b), .oGreen(g_b), .oBlue(b_b),
    .oHSync(hs_b), .oVSync(vs_b), .oDataEnable(de_b), .oFrameStart(fs_b)
  );

  // Video memory contents: a seeded hash of the address
  function automatic logic [2:0] mem_val(input logic [31:0] s, input logic [31:0] a);
    logic [31:0] x;
    x = (a * 32'h9E37_79B1) ^ s;
    x = x ^ (x >> 15);
    return x[2:0];
  endfunction

  // Memory with 1-clock read latency for A
  always @(posedge clk) icol_a <= mem_val(seed, 32'(addr_a));

  // Memory with 3-clock read latency for B
  always @(posedge clk) begin
    ram_b_d[0] <= mem_val(seed, 32'(addr_b));
    ram_b_d[1] <= ram_b_d[0];
    ram_b_d[2] <= ram_b_d[1];
  end
  assign icol_b = ram_b_d[2];

  // Raster model: what pixel number n of a frame looks like
  function automatic pix_t ref_pixel(input cfg_t c, input int n);
    pix_t p;
    int ht, vt, h, v;
    ht = c.ha + c.hfp + c.hsy + c.hbp;
    vt = c.va + c.vfp + c.vsy + c.vbp;
    h = n % ht;
    v = (n / ht) % vt;
    p.hs_on = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsy);
    p.vs_on = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsy);
    p.de    = (h < c.ha) && (v < c.va);
    p.inwin = (h >= c.wx) && (h < c.wx + c.ww) && (v >= c.wy) && (v < c.wy + c.wh);
    p.addr  = p.inwin ? ((v - c.wy) * c.ww + (h - c.wx)) : 0;
    p.fs    = (h == 0) && (v == 0);
    return p;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare one instance's pins, k clocks after the last reset clock
  task automatic check_dut(input string nm, input cfg_t c, input int k, input logic [2:0] border,
                           input logic [31:0] o_addr, input logic o_hs, input logic o_vs,
                           input logic o_de, input logic o_fs, input logic [2:0] o_col);
    int frame, pipe, ea;
    pix_t p;
    logic [2:0] ecol;
    frame = (c.ha + c.hfp + c.hsy + c.hbp) * (c.va + c.vfp + c.vsy + c.vbp);
    pipe = c.ml + 2;
    ea = 0;
    if (k > 0) begin
      p = ref_pixel(c, (k - 1) % frame);
      ea = p.addr;
    end
    check_val({nm, ".addr"}, o_addr, 32'(ea) & ((32'd1 << c.aw) - 32'd1));
    if (k < pipe) begin
      p.hs_on = 1'b0; p.vs_on = 1'b0; p.de = 1'b0; p.inwin = 1'b0; p.fs = 1'b0; p.addr = 0;
    end else begin
      p = ref_pixel(c, (k - pipe) % frame);
    end
    if (p.de && p.inwin) ecol = mem_val(seed, 32'(p.addr));
    else if (p.de) ecol = border;
    else ecol = 3'b000;
    check_val({nm, ".hsync"}, 32'(o_hs), p.hs_on ? c.hpol : 1 - c.hpol);
    check_val({nm, ".vsync"}, 32'(o_vs), p.vs_on ? c.vpol : 1 - c.vpol);
    check_val({nm, ".de"}, 32'(o_de), 32'(p.de));
    check_val({nm, ".frame_start"}, 32'(o_fs), 32'(p.fs));
    check_val({nm, ".color"}, 32'(o_col), 32'(ecol));
  endtask

  initial begin
    cfg_t ca, cb;
    int k, hold, fa, fb, mid_k;
    int hs_cnt_a, vs_cnt_a, de_cnt_a, fs_cnt_a;
    int hs_cnt_b, vs_cnt_b, de_cnt_b, fs_cnt_b;
    bit agg_a_done, agg_b_done, mid_done;

    ca = '{A_HA, A_HFP, A_HSY, A_HBP, A_VA, A_VFP, A_VSY, A_VBP,
           A_WX, A_WY, A_WW, A_WH, A_AW, A_ML, 0, 0};
    cb = '{B_HA, B_HFP, B_HSY, B_HBP, B_VA, B_VFP, B_VSY, B_VBP,
           B_WX, B_WY, B_WW, B_WH, B_AW, B_ML, 1, 1};
    fa = (A_HA + A_HFP + A_HSY + A_HBP) * (A_VA + A_VFP + A_VSY + A_VBP);
    fb = (B_HA + B_HFP + B_HSY + B_HBP) * (B_VA + B_VFP + B_VSY + B_VBP);
    mid_k = 3 * fa + 20 * (A_HA + A_HFP + A_HSY + A_HBP) + 30;
    seed = $urandom;
    k = 0; hold = 5;
    hs_cnt_a = 0; vs_cnt_a = 0; de_cnt_a = 0; fs_cnt_a = 0;
    hs_cnt_b = 0; vs_cnt_b = 0; de_cnt_b = 0; fs_cnt_b = 0;
    agg_a_done = 0; agg_b_done = 0; mid_done = 0;

    for (int cyc = 0; cyc < 18000; cyc++) begin
      border_a = 3'($urandom_range(0, 7));
      border_b = 3'($urandom_range(0, 7));
      rst = (hold > 0);
      if (hold > 0) hold--;
      @(posedge clk);
      if (rst) k = 0;
      else k++;
      #1;
      check_dut("a", ca, k, border_a, 32'(addr_a), hs_a, vs_a, de_a, fs_a, {r_a, g_a, b_a});
      check_dut("b", cb, k, border_b, 32'(addr_b), hs_b, vs_b, de_b, fs_b, {r_b, g_b, b_b});

      // Per-frame totals over the first full frame after power-up reset
      if (k >= A_ML + 2 && k < A_ML + 2 + fa) begin
        hs_cnt_a += int'(hs_a === 1'b0);
        vs_cnt_a += int'(vs_a === 1'b0);
        de_cnt_a += int'(de_a === 1'b1);
        fs_cnt_a += int'(fs_a === 1'b1);
      end
      if (k == A_ML + 1 + fa && !agg_a_done) begin
        agg_a_done = 1;
        check_val("a.hsync_clocks_per_frame", hs_cnt_a, (A_VA + A_VFP + A_VSY + A_VBP) * A_HSY);
        check_val("a.vsync_clocks_per_frame", vs_cnt_a, A_VSY * (A_HA + A_HFP + A_HSY + A_HBP));
        check_val("a.de_clocks_per_frame", de_cnt_a, A_HA * A_VA);
        check_val("a.frame_pulses_per_frame", fs_cnt_a, 1);
      end
      if (k >= B_ML + 2 && k < B_ML + 2 + fb) begin
        hs_cnt_b += int'(hs_b === 1'b1);
        vs_cnt_b += int'(vs_b === 1'b1);
        de_cnt_b += int'(de_b === 1'b1);
        fs_cnt_b += int'(fs_b === 1'b1);
      end
      if (k == B_ML + 1 + fb && !agg_b_done) begin
        agg_b_done = 1;
        check_val("b.hsync_clocks_per_frame", hs_cnt_b, (B_VA + B_VFP + B_VSY + B_VBP) * B_HSY);
        check_val("b.vsync_clocks_per_frame", vs_cnt_b, B_VSY * (B_HA + B_HFP + B_HSY + B_HBP));
        check_val("b.de_clocks_per_frame", de_cnt_b, B_HA * B_VA);
        check_val("b.frame_pulses_per_frame", fs_cnt_b, 1);
      end

      // Reset schedule: one mid-frame reset, then occasional short random ones
      if (!mid_done && k == mid_k) begin
        hold = 2;
        mid_done = 1;
      end else if (cyc > 12000 && hold == 0 && $urandom_range(0, 1499) == 0) begin
        hold = $urandom_range(1, 3);
      end
    end

    check_val("frame_totals_reached", 32'({agg_a_done, agg_b_done, mid_done}), 32'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
